// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU command issuer: opcode encodings,
// result-entry layout and opcode legality helper.
package alu_issuer_pkg;

    localparam logic [2:0] OP_ADD        = 3'b000;
    localparam logic [2:0] OP_SUB        = 3'b001;
    localparam logic [2:0] OP_AND        = 3'b010;
    localparam logic [2:0] OP_OR         = 3'b011;
    localparam logic [2:0] OP_XOR        = 3'b100;
    localparam logic [2:0] OP_LAST_LEGAL = 3'b100;

    // Width of one result FIFO entry: {y[7:0], carry, err}
    localparam int RES_W = 10;

    // Number of bits on the ALU input bus {alu_a, alu_b, alu_op}
    localparam int ISSUE_W = 19;

    typedef struct packed {
        logic [7:0] y;
        logic       carry;
        logic       err;
    } res_entry_t;

    // Opcodes above OP_LAST_LEGAL are reserved and flagged as errors
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_res_fifo.sv
// res_fifo: synchronous FIFO with exported occupancy count.
// The head entry is read combinationally so that an entry pushed at one
// edge is visible at the output right after that edge.
module res_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg,  count_next;
    logic          do_push;
    logic          do_pop;

    // Full/empty guards make push-when-full and pop-when-empty harmless
    assign do_push = push && (count_reg != DEPTH_L);
    assign do_pop  = pop  && (count_reg != '0);

    // Pointer and count update; pointers wrap naturally since DEPTH is 2^AW
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointer/count state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage array; contents need no reset because count gates validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data  = mem[rd_ptr_reg];
    assign head_valid = (count_reg != '0);
    assign count      = count_reg;

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: registers commands onto the combinational ALU input bus,
// captures the ALU result one cycle later into a result FIFO, and supports
// chained (accumulate) commands with result forwarding.
// Optional feature macro: ALU_TOGGLE_CNT_EN adds a saturating switching
// activity counter on {alu_a, alu_b, alu_op} and the toggle_count port.
module alu_cmd_issuer
    import alu_issuer_pkg::*;
#(
    parameter int RES_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_chain,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_y,
    input  logic        alu_carry,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_y,
    output logic        res_carry,
    output logic        res_err,
    output logic        busy
`ifdef ALU_TOGGLE_CNT_EN
    ,
    output logic [15:0] toggle_count
`endif
);

    localparam int CW = $clog2(RES_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(RES_DEPTH);

    logic [7:0] alu_a_reg,  alu_a_next;
    logic [7:0] alu_b_reg,  alu_b_next;
    logic [2:0] alu_op_reg, alu_op_next;
    logic       s1_valid_reg, s1_valid_next;
    logic [7:0] acc_reg,    acc_next;

    logic       accept;
    logic       s1_legal;
    logic [7:0] chain_a;
    logic [CW:0] occupancy;

    res_entry_t   push_entry;
    res_entry_t   head_entry;
    logic         head_valid;
    logic [CW-1:0] fifo_count;

    // Credit check counts the in-flight command as an already-reserved slot,
    // so a full pipeline never overruns the FIFO and res_ready has no
    // combinational path to cmd_ready.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_reg};
    assign cmd_ready = (occupancy < DEPTH_L);
    assign accept    = cmd_valid && cmd_ready;

    // A chained command takes the freshest legal result: the one on the ALU
    // output right now if a legal command is in flight, else the accumulator.
    assign s1_legal = op_is_legal(alu_op_reg);
    assign chain_a  = (s1_valid_reg && s1_legal) ? alu_y : acc_reg;

    // Issue stage: load the ALU bus on accept, otherwise hold it steady
    always_comb begin
        alu_a_next    = alu_a_reg;
        alu_b_next    = alu_b_reg;
        alu_op_next   = alu_op_reg;
        s1_valid_next = accept;
        if (accept) begin
            alu_a_next  = cmd_chain ? chain_a : cmd_a;
            alu_b_next  = cmd_b;
            alu_op_next = cmd_op;
        end
    end

    // Accumulator follows every captured legal result; illegal ops skip it
    always_comb begin
        acc_next = acc_reg;
        if (s1_valid_reg && s1_legal) begin
            acc_next = alu_y;
        end
    end

    // Issue-stage and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= '0;
            s1_valid_reg <= 1'b0;
            acc_reg      <= '0;
        end else begin
            alu_a_reg    <= alu_a_next;
            alu_b_reg    <= alu_b_next;
            alu_op_reg   <= alu_op_next;
            s1_valid_reg <= s1_valid_next;
            acc_reg      <= acc_next;
        end
    end

    // Capture entry assembled from the ALU response to the in-flight command
    always_comb begin
        push_entry.y     = alu_y;
        push_entry.carry = alu_carry;
        push_entry.err   = !s1_legal;
    end

    res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (s1_valid_reg),
        .push_data  (push_entry),
        .pop        (res_ready),
        .head_data  (head_entry),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign res_valid = head_valid;
    // Head fields read as zero while empty so stale storage is never shown
    assign res_y     = head_valid ? head_entry.y     : 8'h00;
    assign res_carry = head_valid ? head_entry.carry : 1'b0;
    assign res_err   = head_valid ? head_entry.err   : 1'b0;
    assign busy      = s1_valid_reg || (fifo_count != '0);

`ifdef ALU_TOGGLE_CNT_EN
    logic [ISSUE_W-1:0] issue_cur;
    logic [ISSUE_W-1:0] issue_nxt;
    logic [ISSUE_W-1:0] toggle_bits;
    logic [4:0]         toggle_pop;
    logic [16:0]        toggle_sum;
    logic [15:0]        toggle_reg, toggle_next;

    assign issue_cur = {alu_a_reg,  alu_b_reg,  alu_op_reg};
    assign issue_nxt = {alu_a_next, alu_b_next, alu_op_next};

    // One flag per ALU input bit that flips at the coming edge
    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_toggle
        assign toggle_bits[gi] = issue_cur[gi] ^ issue_nxt[gi];
    end

    // Popcount of flipped bits, accumulated with saturation at 16'hFFFF
    always_comb begin
        toggle_pop = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            toggle_pop = toggle_pop + {4'b0000, toggle_bits[i]};
        end
        toggle_sum  = {1'b0, toggle_reg} + {12'h000, toggle_pop};
        toggle_next = toggle_sum[16] ? 16'hFFFF : toggle_sum[15:0];
    end

    // Switching-activity counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_reg <= '0;
        end else begin
            toggle_reg <= toggle_next;
        end
    end

    assign toggle_count = toggle_reg;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer. A stand-in combinational ALU is
// wired to the issuer; a queue-based model tracks expected results.
module tb_alu_cmd_issuer;

    localparam int D = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        cmd_chain;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_y;
    logic        alu_carry;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_y;
    logic        res_carry;
    logic        res_err;
    logic        busy;
`ifdef ALU_TOGGLE_CNT_EN
    logic [15:0] toggle_count;
`endif

    alu_cmd_issuer #(.RES_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_chain (cmd_chain),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .alu_carry (alu_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_carry (res_carry),
        .res_err   (res_err),
        .busy      (busy)
`ifdef ALU_TOGGLE_CNT_EN
        ,
        .toggle_count (toggle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU behaviour: returns {carry, y}; illegal opcodes give zero
    function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} - {1'b0, b};
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, a | b};
            3'b100:  return {1'b0, a ^ b};
            default: return 9'h000;
        endcase
    endfunction

    // Stand-in for the real ALU on the issuer's bus
    always_comb begin
        {alu_carry, alu_y} = alu_fn(alu_op, alu_a, alu_b);
    end

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       e;
    } ent_t;

    ent_t        q[$];
    bit          pend_v;
    ent_t        pend;
    logic [7:0]  macc;
    logic [7:0]  ea, eb;
    logic [2:0]  eop;
    int          etog;
    int          tests;
    int          fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every observable output against the model
    task automatic check_all();
        chk("cmd_ready", cmd_ready, (q.size() + pend_v) < D);
        chk("res_valid", res_valid, q.size() != 0);
        chk("busy", busy, pend_v || (q.size() != 0));
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_op, eop);
        if (q.size() != 0) begin
            chk("res_y", res_y, q[0].y);
            chk("res_carry", res_carry, q[0].c);
            chk("res_err", res_err, q[0].e);
        end
`ifdef ALU_TOGGLE_CNT_EN
        chk("toggle_count", toggle_count, etog);
`endif
    endtask

    // Advance one clock: model decides accept/pop from pre-edge state,
    // then outputs are checked 1 time unit after the edge.
    task automatic tick();
        bit          acc_ok;
        bit          pop_ok;
        ent_t        nw;
        logic [7:0]  opa;
        logic [8:0]  r;
        logic [18:0] diff;
        acc_ok = 1'b0;
        pop_ok = 1'b0;
        nw = '{8'h00, 1'b0, 1'b0};
        if (!rst) begin
            acc_ok = cmd_valid && ((q.size() + pend_v) < D);
            pop_ok = res_ready && (q.size() != 0);
            if (acc_ok) begin
                // A chained command sees the latest legal result accepted
                opa = cmd_chain ? macc : cmd_a;
                r = alu_fn(cmd_op, opa, cmd_b);
                nw = '{r[7:0], r[8], cmd_op > 3'd4};
                if (cmd_op <= 3'd4) macc = r[7:0];
                diff = {opa, cmd_b, cmd_op} ^ {ea, eb, eop};
                etog = etog + $countones(diff);
                if (etog > 65535) etog = 65535;
                ea = opa;
                eb = cmd_b;
                eop = cmd_op;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            pend_v = 1'b0;
            macc = 8'h00;
            ea = 8'h00;
            eb = 8'h00;
            eop = 3'b000;
            etog = 0;
        end else begin
            if (pop_ok) void'(q.pop_front());
            if (pend_v) q.push_back(pend);
            pend_v = acc_ok;
            pend = nw;
        end
        check_all();
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic chain);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_chain = chain;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Literal check of the FIFO head, then pop it
    task automatic drain_expect(input string name, input logic [7:0] y, input logic c, input logic e);
        chk({name, "_valid"}, res_valid, 1'b1);
        chk({name, "_y"}, res_y, y);
        chk({name, "_carry"}, res_carry, c);
        chk({name, "_err"}, res_err, e);
        $display("[TB] result %s: y=%02h carry=%0d err=%0d", name, res_y, res_carry, res_err);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int accepts;
        tests = 0;
        fails = 0;
        q.delete();
        pend_v = 1'b0;
        macc = 8'h00;
        ea = 8'h00;
        eb = 8'h00;
        eop = 3'b000;
        etog = 0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'b000;
        cmd_a = 8'h00;
        cmd_b = 8'h00;
        cmd_chain = 1'b0;
        res_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_y", res_y, 8'h00);
        chk("rst_res_carry", res_carry, 1'b0);
        chk("rst_res_err", res_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_a", alu_a, 8'h00);

        // Add with carry out, one-cycle latency
        send(3'b000, 8'hF0, 8'h20, 1'b0);
        chk("lat_not_yet", res_valid, 1'b0);
        tick();
        drain_expect("add", 8'h10, 1'b1, 1'b0);

        // Sub with borrow, then or
        send(3'b001, 8'h05, 8'h07, 1'b0);
        send(3'b011, 8'h0F, 8'hF0, 1'b0);
        tick();
        drain_expect("sub", 8'hFE, 1'b1, 1'b0);
        drain_expect("or", 8'hFF, 1'b0, 1'b0);

        // Back-to-back chained commands with forwarding
        send(3'b000, 8'h10, 8'h01, 1'b0);
        send(3'b000, 8'hAA, 8'h02, 1'b1);
        send(3'b100, 8'h55, 8'hFF, 1'b1);
        tick();
        drain_expect("fwd0", 8'h11, 1'b0, 1'b0);
        drain_expect("fwd1", 8'h13, 1'b0, 1'b0);
        drain_expect("fwd2", 8'hEC, 1'b0, 1'b0);

        // Illegal opcode leaves the accumulator untouched
        send(3'b000, 8'h03, 8'h04, 1'b0);
        send(3'b110, 8'h55, 8'h66, 1'b0);
        send(3'b000, 8'h99, 8'h01, 1'b1);
        tick();
        drain_expect("ill0", 8'h07, 1'b0, 1'b0);
        drain_expect("ill1", 8'h00, 1'b0, 1'b1);
        drain_expect("ill2", 8'h08, 1'b0, 1'b0);

        // Back-pressure: exactly RES_DEPTH accepts with res_ready held low
        accepts = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_op = 3'($urandom_range(0, 4));
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            cmd_chain = 1'b0;
            if (cmd_valid && cmd_ready) accepts++;
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_accepts", accepts, D);
        chk("bp_full_ready", cmd_ready, 1'b0);
        $display("[TB] backpressure: %0d accepts, cmd_ready=%0d", accepts, cmd_ready);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_ready_after_pop", cmd_ready, 1'b1);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        res_ready = 1'b0;
        chk("bp_drained_busy", busy, 1'b0);

        // Reset mid-stream: 3 queued, 1 in flight
        for (int i = 0; i < 4; i++) send(3'b000, 8'(i + 1), 8'h10, 1'b0);
        chk("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_res_valid", res_valid, 1'b0);
        chk("mid_busy", busy, 1'b0);
`ifdef ALU_TOGGLE_CNT_EN
        chk("mid_toggle", toggle_count, 16'h0000);
`endif
        tick();
        chk("mid_res_valid2", res_valid, 1'b0);
        send(3'b000, 8'h77, 8'h05, 1'b1);
        tick();
        drain_expect("mid_chain", 8'h05, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) cmd_op = 3'($urandom_range(5, 7));
            else                           cmd_op = 3'($urandom_range(0, 4));
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            cmd_chain = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < D + 2; i++) tick();
        chk("final_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side driver for the 8-bit combinational ALU. It accepts operation commands over a valid/ready handshake and registers operands and opcode onto the ALU input bus. One cycle later it captures the ALU result and carry into a result FIFO, which drains over a second valid/ready handshake. It also supports chained (accumulate) commands and optional switching-activity counting for power characterisation.

## Interface
- `RES_DEPTH`, 4: result FIFO depth; power of two, at least 2.
- `clk` in 1: single clock; all logic updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: issuer accepts a command this cycle.
- `cmd_op` in 3: opcode. 000 add, 001 sub, 010 and, 011 or, 100 xor; 101–111 are illegal.
- `cmd_a` in 8: operand A. Ignored when `cmd_chain`=1.
- `cmd_b` in 8: operand B.
- `cmd_chain` in 1: use the accumulator as operand A.
- `alu_a` out 8: registered ALU operand A.
- `alu_b` out 8: registered ALU operand B.
- `alu_op` out 3: registered ALU opcode.
- `alu_y` in 8: ALU result.
- `alu_carry` in 1: ALU carry/borrow.
- `res_valid` out 1: FIFO head valid.
- `res_ready` in 1: consumer takes the head.
- `res_y` out 8: result at the FIFO head.
- `res_carry` out 1: carry at the FIFO head.
- `res_err` out 1: head entry came from an illegal opcode.
- `busy` out 1: a command is in flight or the FIFO is non-empty.
- `toggle_count` out 16: present only when `ALU_TOGGLE_CNT_EN` is defined.

## Operation
- Accept happens when `cmd_valid && cmd_ready` at edge N. At that edge `alu_a`, `alu_b` and `alu_op` load, and the in-flight flag `s1_valid` sets.
- Capture happens at edge N+1 if `s1_valid`. The FIFO pushes {`alu_y`, `alu_carry`, err}, where err = (`alu_op` > 3'b100).
- On capture of a legal opcode, `acc` ← `alu_y`. An illegal opcode leaves `acc` unchanged; its entry is pushed with y and carry as delivered by the ALU, which are 0.
- Chained operand A:
  - If `s1_valid` and the in-flight opcode is legal, A = `alu_y` (forwarded).
  - If `s1_valid` and the in-flight opcode is illegal, A = `acc`.
  - Otherwise A = `acc`.
- Back-to-back chained commands therefore see the immediately preceding result with no bubble.
- Condition for accepting: `cmd_ready` = (fifo_count + `s1_valid`) < `RES_DEPTH`.
  - It is computed from registered state only; there is no combinational path from `res_ready` or `cmd_valid`.
- A pop occurs when `res_valid && res_ready`. A push and a pop in the same cycle leave the count unchanged.
- With no accept, `alu_*` hold their last values. They are not zeroed, so the ALU sees no spurious activity.
- Carry is passed through unchanged. For sub it is the 9-bit borrow: 1 when a < b unsigned. For logic ops it is 0.
- `busy` = `s1_valid` | (fifo_count != 0).

## Timing
- Reset values:
  - `alu_a`, `alu_b`, `alu_op`, `acc`, `s1_valid`, fifo_count: 0.
  - `res_valid`=0, `res_y`=0, `res_carry`=0, `res_err`=0, `busy`=0.
  - `cmd_ready`=1 in the cycle after reset.
  - `toggle_count`=0.
- Latency: a command accepted at edge N gives `res_valid`=1 after edge N+1 if the FIFO was empty.
- Throughput: one command per cycle while not back-pressured.
- Reset asserted mid-stream discards the in-flight command and all FIFO contents and clears `acc`. No result from before reset is ever presented.
- Full boundary: with `RES_DEPTH` entries plus in-flight accounted for, `cmd_ready`=0. It returns to 1 in the cycle after the first pop.
- Pointers wrap modulo `RES_DEPTH`.

## Configuration
- `ALU_TOGGLE_CNT_EN` defined:
  - A 16-bit saturating counter adds, each cycle, the popcount of the bits of {`alu_a`,`alu_b`,`alu_op`} that changed at that edge (0–19 per cycle).
  - It holds at 16'hFFFF once saturated, clears on `rst`, and drives `toggle_count`.
- `ALU_TOGGLE_CNT_EN` undefined: the counter and the `toggle_count` port are absent; all other behaviour is identical.

## Structure
- Package `alu_issuer_pkg` holds:
  - Opcode localparams: `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_XOR`, `OP_LAST_LEGAL`=3'b100.
  - The result-entry width (10 bits).
- One sub-module: `res_fifo`, a synchronous FIFO with parameterised width and depth that exports a count.
- The issue stage, forwarding and toggle counter stay in `alu_cmd_issuer`. The top-level bench connects it to the existing `alu`.

## Test plan
- Add, 0xF0 + 0x20, accepted at edge N → after edge N+1: `res_valid`=1, `res_y`=0x10, `res_carry`=1, `res_err`=0.
- Sub, 0x05 − 0x07 → `res_y`=0xFE, `res_carry`=1. Then or, 0x0F | 0xF0 → `res_y`=0xFF, `res_carry`=0.
- Forwarding: add 0x10+0x01, then a chained add with b=0x02 on the very next cycle, then a chained xor with b=0xFF → results 0x11, 0x13, 0xEC.
- Illegal op: add 0x03+0x04, then op 3'b110, then a chained add with b=0x01 → 0x07; then y=0 with `res_err`=1; then 0x08.
- Back-pressure: `RES_DEPTH`=4, `res_ready`=0, `cmd_valid` held → exactly 4 accepts, then `cmd_ready`=0. Raise `res_ready` for 1 cycle → `cmd_ready`=1 on the following cycle; FIFO order is preserved.
- Reset mid-stream: 3 results queued plus 1 in flight, assert `rst` for 1 cycle → next cycle `res_valid`=0, `busy`=0, a chained add with b=0x05 yields 0x05. With `ALU_TOGGLE_CNT_EN`, `toggle_count`=0.
